// File: rtl/bcd_entry_buffer.sv
// Keypad number-entry register for the RPN calculator.
// Builds a signed BCD operand one key at a time and offers it downstream on ENTER.

// Shifts a BCD word left by i_amt digits (0 or 1), inserting i_digit at the bottom.
module bcd_left_shifter #(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic [NUM_DIGITS*4-1:0] i_num,
    input  logic [3:0]              i_digit,
    input  logic                    i_amt,
    output logic [NUM_DIGITS*4-1:0] o_num
);

    localparam int unsigned W = NUM_DIGITS * 4;

    // Single-digit shift: drop the top digit, append the new one at digit 0
    always_comb begin
        o_num = i_num;
        if (i_amt) begin
            o_num = {i_num[W-5:0], i_digit};
        end
    end

endmodule

module bcd_entry_buffer #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_key_valid,
    output logic                    o_key_ready,
    input  logic [3:0]              i_key,
    output logic [NUM_DIGITS*4-1:0] o_num,
    output logic                    o_neg,
    output logic [CNT_W-1:0]        o_len,
    output logic                    o_reject,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [NUM_DIGITS*4-1:0] o_out_num,
    output logic                    o_out_neg
);

    localparam int unsigned W = NUM_DIGITS * 4;

    localparam logic [3:0] KEY_BKSP  = 4'd10;
    localparam logic [3:0] KEY_CLEAR = 4'd11;
    localparam logic [3:0] KEY_SIGN  = 4'd12;
    localparam logic [3:0] KEY_ENTER = 4'd13;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    localparam logic [CNT_W-1:0] LEN_FULL = CNT_W'(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LEN_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   shifted_num;

    bcd_left_shifter #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_shifter (
        .i_num   (o_num),
        .i_digit (i_key),
        .i_amt   (1'b1),
        .o_num   (shifted_num)
    );

    // Keys are only taken while nothing is being offered downstream
    assign o_key_ready = (state != HOLD);

    // Entry FSM: key decode, operand update and the downstream handshake
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_num       <= '0;
            o_neg       <= 1'b0;
            o_len       <= '0;
            o_reject    <= 1'b0;
            o_out_valid <= 1'b0;
            o_out_num   <= '0;
            o_out_neg   <= 1'b0;
        end else begin
            o_reject <= 1'b0;
            if (state == HOLD) begin
                if (i_out_ready) begin
                    o_out_valid <= 1'b0;
                    state       <= IDLE;
                end
            end else if (i_key_valid) begin
                if (i_key <= DIGIT_MAX) begin
                    if (o_len == LEN_FULL) begin
                        o_reject <= 1'b1;
                    end else if ((o_len == '0) && (i_key == 4'd0)) begin
                        state <= ENTRY;
                    end else begin
                        o_num <= shifted_num;
                        o_len <= o_len + LEN_ONE;
                        state <= ENTRY;
                    end
                end else begin
                    case (i_key)
                        KEY_BKSP: begin
                            if (o_len != '0) begin
                                o_num <= o_num >> 4;
                                o_len <= o_len - LEN_ONE;
                                if (o_len == LEN_ONE) begin
                                    o_neg <= 1'b0;
                                end
                            end
                        end
                        KEY_CLEAR: begin
                            o_num <= '0;
                            o_len <= '0;
                            o_neg <= 1'b0;
                            state <= IDLE;
                        end
                        KEY_SIGN: begin
                            if (o_len != '0) begin
                                o_neg <= ~o_neg;
                            end
                        end
                        KEY_ENTER: begin
                            if (state == IDLE) begin
                                o_reject <= 1'b1;
                            end else begin
                                o_out_num   <= o_num;
                                o_out_neg   <= o_neg;
                                o_out_valid <= 1'b1;
                                o_num       <= '0;
                                o_neg       <= 1'b0;
                                o_len       <= '0;
                                state       <= HOLD;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_entry_buffer.sv
// Self-checking bench for bcd_entry_buffer (NUM_DIGITS = 4) against a decimal-value model.
module tb_bcd_entry_buffer;

    localparam int unsigned ND = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic        key_ready;
    logic [3:0]  key;
    logic [15:0] num;
    logic        neg;
    logic [2:0]  len;
    logic        reject;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_num;
    logic        out_neg;

    int checks = 0;
    int errors = 0;

    // Reference model: operand as a plain decimal integer plus flags
    int m_value  = 0;
    int m_len    = 0;
    bit m_neg    = 0;
    bit m_entry  = 0;
    bit m_hold   = 0;
    bit m_rej    = 0;
    bit m_ovalid = 0;
    int m_onum   = 0;
    bit m_oneg   = 0;

    bcd_entry_buffer #(.NUM_DIGITS(ND)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_key_valid (key_valid),
        .o_key_ready (key_ready),
        .i_key       (key),
        .o_num       (num),
        .o_neg       (neg),
        .o_len       (len),
        .o_reject    (reject),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_num   (out_num),
        .o_out_neg   (out_neg)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] tobcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [39:0] obs_vec();
        return {num, neg, len, reject, out_valid, key_ready, out_num, out_neg};
    endfunction

    function automatic logic [39:0] exp_vec();
        return {tobcd(m_value), m_neg, 3'(m_len), m_rej, m_ovalid, ~m_hold, tobcd(m_onum), m_oneg};
    endfunction

    task automatic model_update(input logic r_n, input logic v, input logic [3:0] k, input logic rdy);
        m_rej = 0;
        if (!r_n) begin
            m_value = 0; m_len = 0; m_neg = 0; m_entry = 0; m_hold = 0;
            m_ovalid = 0; m_onum = 0; m_oneg = 0;
        end else if (m_hold) begin
            if (rdy) begin
                m_ovalid = 0;
                m_hold   = 0;
                m_entry  = 0;
            end
        end else if (v) begin
            if (k <= 4'd9) begin
                if (m_len == ND) m_rej = 1;
                else begin
                    m_entry = 1;
                    if (!(m_len == 0 && k == 4'd0)) begin
                        m_value = m_value * 10 + int'(k);
                        m_len   = m_len + 1;
                    end
                end
            end else if (k == 4'd10) begin
                if (m_len > 0) begin
                    m_value = m_value / 10;
                    m_len   = m_len - 1;
                    if (m_len == 0) m_neg = 0;
                end
            end else if (k == 4'd11) begin
                m_value = 0; m_len = 0; m_neg = 0; m_entry = 0;
            end else if (k == 4'd12) begin
                if (m_len > 0) m_neg = ~m_neg;
            end else if (k == 4'd13) begin
                if (!m_entry) m_rej = 1;
                else begin
                    m_onum = m_value; m_oneg = m_neg; m_ovalid = 1; m_hold = 1;
                    m_value = 0; m_neg = 0; m_len = 0; m_entry = 0;
                end
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, return at the sampling edge
    task automatic step(input logic r_n, input logic v, input logic [3:0] k, input logic rdy);
        rst_n = r_n; key_valid = v; key = k; out_ready = rdy;
        @(posedge clk);
        model_update(r_n, v, k, rdy);
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        step(1'b1, 1'b1, k, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 4'd13, 1'b1);
        checks++;
        if (obs_vec() !== 40'h00_0000_2000 >> 0 && obs_vec() !== {16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), {16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0});
        end
    endtask

    task automatic test_digits();
        press(4'd1); press(4'd2); press(4'd3);
        checks++;
        if (num !== 16'h0123 || len !== 3'd3) begin
            errors++;
            $display("FAIL digits_123: num=%h len=%0d expected 0123 len 3", num, len);
        end
        press(4'd4);
        checks++;
        if (num !== 16'h1234 || len !== 3'd4 || reject !== 1'b0) begin
            errors++;
            $display("FAIL digits_1234: num=%h len=%0d rej=%b expected 1234 len 4 rej 0", num, len, reject);
        end
        press(4'd5);
        checks++;
        if (num !== 16'h1234 || len !== 3'd4 || reject !== 1'b1) begin
            errors++;
            $display("FAIL digit_overflow: num=%h len=%0d rej=%b expected 1234 len 4 rej 1", num, len, reject);
        end
        step(1'b1, 1'b0, 4'd0, 1'b0);
        checks++;
        if (reject !== 1'b0) begin
            errors++;
            $display("FAIL reject_pulse: rej=%b expected 0", reject);
        end
    endtask

    task automatic test_leading_zero();
        press(4'd11);
        press(4'd0); press(4'd0);
        checks++;
        if (num !== 16'h0 || len !== 3'd0) begin
            errors++;
            $display("FAIL leading_zero: num=%h len=%0d expected 0000 len 0", num, len);
        end
        press(4'd7);
        checks++;
        if (num !== 16'h0007 || len !== 3'd1) begin
            errors++;
            $display("FAIL digit_7: num=%h len=%0d expected 0007 len 1", num, len);
        end
        step(1'b1, 1'b1, 4'd13, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_num !== 16'h0007 || key_ready !== 1'b0 || num !== 16'h0) begin
            errors++;
            $display("FAIL enter_7: valid=%b out=%h rdy=%b num=%h expected 1 0007 0 0000", out_valid, out_num, key_ready, num);
        end
        step(1'b1, 1'b0, 4'd0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_num !== 16'h0007 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL transfer_7: valid=%b out=%h rdy=%b expected 0 0007 1", out_valid, out_num, key_ready);
        end
    endtask

    task automatic test_sign_bksp();
        press(4'd9); press(4'd8); press(4'd12);
        checks++;
        if (neg !== 1'b1 || num !== 16'h0098) begin
            errors++;
            $display("FAIL sign: neg=%b num=%h expected 1 0098", neg, num);
        end
        press(4'd10); press(4'd10);
        checks++;
        if (num !== 16'h0 || len !== 3'd0 || neg !== 1'b0) begin
            errors++;
            $display("FAIL bksp_empty: num=%h len=%0d neg=%b expected 0000 0 0", num, len, neg);
        end
        press(4'd13);
        checks++;
        if (out_valid !== 1'b1 || out_num !== 16'h0 || out_neg !== 1'b0 || reject !== 1'b0) begin
            errors++;
            $display("FAIL enter_zero: valid=%b out=%h oneg=%b rej=%b expected 1 0000 0 0", out_valid, out_num, out_neg, reject);
        end
        step(1'b1, 1'b0, 4'd0, 1'b1);
    endtask

    task automatic test_hold();
        press(4'd4); press(4'd2); press(4'd13);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 4'd7, 1'b0);
            checks++;
            if (key_ready !== 1'b0 || out_valid !== 1'b1 || out_num !== 16'h0042 || num !== 16'h0) begin
                errors++;
                $display("FAIL hold_%0d: rdy=%b valid=%b out=%h num=%h expected 0 1 0042 0000", i, key_ready, out_valid, out_num, num);
            end
        end
        step(1'b1, 1'b1, 4'd7, 1'b1);
        checks++;
        if (key_ready !== 1'b1 || out_valid !== 1'b0 || num !== 16'h0) begin
            errors++;
            $display("FAIL hold_release: rdy=%b valid=%b num=%h expected 1 0 0000", key_ready, out_valid, num);
        end
        press(4'd3);
        checks++;
        if (num !== 16'h0003 || len !== 3'd1) begin
            errors++;
            $display("FAIL keys_resume: num=%h len=%0d expected 0003 1", num, len);
        end
    endtask

    task automatic test_idle_keys();
        step(1'b0, 1'b0, 4'd0, 1'b0);
        press(4'd13);
        checks++;
        if (reject !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL enter_idle: rej=%b valid=%b expected 1 0", reject, out_valid);
        end
        press(4'd12);
        checks++;
        if (reject !== 1'b0 || neg !== 1'b0 || len !== 3'd0) begin
            errors++;
            $display("FAIL sign_idle: rej=%b neg=%b len=%0d expected 0 0 0", reject, neg, len);
        end
        press(4'd14); press(4'd15);
        checks++;
        if (reject !== 1'b0 || num !== 16'h0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL noop_keys: rej=%b num=%h rdy=%b expected 0 0000 1", reject, num, key_ready);
        end
    endtask

    task automatic test_reset_hold();
        press(4'd5); press(4'd12); press(4'd13);
        step(1'b0, 1'b1, 4'd1, 1'b0);
        checks++;
        if (obs_vec() !== {16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_in_hold: got %h expected %h", obs_vec(), {16'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0});
        end
    endtask

    task automatic test_random();
        logic [3:0] k;
        for (int i = 0; i < 3000; i++) begin
            k = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), k, $urandom_range(0, 1) != 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_%0d: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; key_valid = 1'b0; key = 4'd0; out_ready = 1'b0;
        test_reset();
        test_digits();
        test_leading_zero();
        test_sign_bksp();
        test_hold();
        test_idle_keys();
        test_reset_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
